// File: rtl/xbar_return_arbiter_pkg.sv
// Shared types and helpers for the crossbar return-path arbiter: FSM states,
// index-width helpers and the round-robin pick function.
package xbar_return_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MAX_N = 32;

    function automatic int slv_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int mst_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester at or after ptr, wrapping at n; returns ptr when nobody requests.
    function automatic int rr_pick(input logic [RR_MAX_N-1:0] req, input int ptr, input int n);
        int idx;
        int result;
        result = ptr;
        for (int k = RR_MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/xbar_return_arbiter_rr_pick.sv
// Pure combinational rotate-priority picker; reusable by the forward arbiter.
module rr_pick_comb
    import xbar_return_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_idx
);

    logic [RR_MAX_N-1:0] w_req_ext;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = i_req;
        o_idx            = W'(rr_pick(w_req_ext, int'(i_ptr), N));
    end

endmodule

// File: rtl/xbar_return_arbiter.sv
// Master-side return-path round-robin scheduler across slave return FIFOs.
// XBAR_RETURN_BURST_LOCK_EN: hold the grant until the last beat of a burst.
//
// state | meaning
// IDLE  | no grant; waiting for any slave front entry addressed to this master
// GRANT | grant_slave_number valid; beats drain while the master FIFO has room
module xbar_return_arbiter
    import xbar_return_arbiter_pkg::*;
#(
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0,
    localparam int MW = mst_idx_w(masters),
    localparam int SW = slv_idx_w(slaves)
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic [slaves-1:0] slave_fifo_empty,
    input  logic [MW-1:0] slave_dest_master [0:slaves-1],
    input  logic [slaves-1:0] slave_front_last,
    input  logic          master_fifo_full,
    output logic [SW-1:0] grant_slave_number,
    output logic          push_to_fifo,
    output logic [15:0]   transfer_count
);

    arb_state_t      r_state;
    logic [SW-1:0]   r_grant;
    logic [SW-1:0]   r_rr_ptr;
    logic [15:0]     r_count;

    logic [slaves-1:0] w_req;
    logic [slaves-1:0] w_req_nxt;
    logic [slaves-1:0] w_gnt_onehot;
    logic [SW-1:0]     w_grant_inc;
    logic [SW-1:0]     w_pick_idle;
    logic [SW-1:0]     w_pick_next;
    logic              w_xfer;
    logic              w_last;
    logic              w_mid_burst;

    always_comb begin
        w_req = '0;
        for (int s = 0; s < slaves; s++) begin
            w_req[s] = ~slave_fifo_empty[s] & (slave_dest_master[s] == MW'(i_am_master_number));
        end
    end

    // A granted slave that is the only requester is dropped so the FSM falls back to IDLE.
    assign w_gnt_onehot = slaves'(1) << r_grant;
    assign w_req_nxt    = (w_req == w_gnt_onehot) ? '0 : w_req;
    assign w_grant_inc  = (r_grant == SW'(slaves - 1)) ? '0 : r_grant + 1'b1;

    assign push_to_fifo       = (r_state == GRANT) & w_req[r_grant];
    assign w_xfer             = push_to_fifo & ~master_fifo_full;
    assign grant_slave_number = r_grant;
    assign transfer_count     = r_count;

`ifdef XBAR_RETURN_BURST_LOCK_EN
    logic r_mid_burst;

    assign w_last      = slave_front_last[r_grant];
    assign w_mid_burst = r_mid_burst;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_mid_burst <= 1'b0;
        end else if (w_xfer) begin
            r_mid_burst <= ~w_last;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^slave_front_last;
    assign w_last        = 1'b1;
    assign w_mid_burst   = 1'b0;
`endif

    rr_pick_comb #(.N(slaves), .W(SW)) u_pick_idle (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idle)
    );

    rr_pick_comb #(.N(slaves), .W(SW)) u_pick_next (
        .i_req (w_req_nxt),
        .i_ptr (w_grant_inc),
        .o_idx (w_pick_next)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_pick_idle;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer && w_last) begin
                        r_rr_ptr <= w_grant_inc;
                        if (|w_req_nxt) begin
                            r_grant <= w_pick_next;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (!w_xfer && !w_req[r_grant] && !w_mid_burst) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_count <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_xbar_return_arbiter.sv
// Directed bench for xbar_return_arbiter (masters=2, slaves=2, master 0);
// burst-lock steps run when XBAR_RETURN_BURST_LOCK_EN is defined, interleave steps otherwise.
module tb_xbar_return_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [1:0]  slave_fifo_empty;
    logic [0:0]  slave_dest_master [0:1];
    logic [1:0]  slave_front_last;
    logic        master_fifo_full;
    logic [0:0]  grant_slave_number;
    logic        push_to_fifo;
    logic [15:0] transfer_count;

    xbar_return_arbiter #(
        .masters            (2),
        .slaves             (2),
        .i_am_master_number (0)
    ) dut (
        .ACLK               (ACLK),
        .ARESETn            (ARESETn),
        .slave_fifo_empty   (slave_fifo_empty),
        .slave_dest_master  (slave_dest_master),
        .slave_front_last   (slave_front_last),
        .master_fifo_full   (master_fifo_full),
        .grant_slave_number (grant_slave_number),
        .push_to_fifo       (push_to_fifo),
        .transfer_count     (transfer_count)
    );

    always #5 ACLK = ~ACLK;

    // Slave return FIFO contents: bit 1 = dest master, bit 0 = last.
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] gate;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_cnt = 0;
    logic       s_push;
    logic       s_full;
    logic [0:0] s_grant;

    task automatic drive();
        slave_fifo_empty[0]  = (q0.size() == 0) | gate[0];
        slave_dest_master[0] = (q0.size() != 0) ? q0[0][1] : 1'b0;
        slave_front_last[0]  = (q0.size() != 0) ? q0[0][0] : 1'b0;
        slave_fifo_empty[1]  = (q1.size() == 0) | gate[1];
        slave_dest_master[1] = (q1.size() != 0) ? q1[0][1] : 1'b0;
        slave_front_last[1]  = (q1.size() != 0) ? q1[0][0] : 1'b0;
    endtask

    task automatic settle();
        drive();
        #1;
        s_push  = push_to_fifo;
        s_grant = grant_slave_number;
        s_full  = master_fifo_full;
    endtask

    task automatic cyc();
        @(posedge ACLK);
        if (s_push && !s_full) begin
            if (s_grant == 1'b0) q0.delete(0);
            else                 q1.delete(0);
        end
        #1;
        settle();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETn          = 1'b0;
        gate             = 2'b00;
        master_fifo_full = 1'b0;
        settle();
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        settle();
        check("rst_grant", 32'(grant_slave_number), 0);
        check("rst_push",  32'(push_to_fifo), 0);
        check("rst_count", 32'(transfer_count), 0);
        repeat (3) cyc();
        check("idle_push", 32'(push_to_fifo), 0);

        // Single beat from slave 1: grant follows one cycle after the request.
        q1.push_back(2'b01);
        settle();
        check("t1_req_push", 32'(push_to_fifo), 0);
        cyc();
        check("t1_grant", 32'(grant_slave_number), 1);
        check("t1_push",  32'(push_to_fifo), 1);
        cyc();
        exp_cnt = 1;
        check("t1_count", 32'(transfer_count), exp_cnt);
        check("t1_idle_push", 32'(push_to_fifo), 0);

`ifdef XBAR_RETURN_BURST_LOCK_EN
        // Two 4-beat bursts: slave 0 then slave 1 with no bubble between.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(2'b00);
            q1.push_back(2'b00);
        end
        q0.push_back(2'b01);
        q1.push_back(2'b01);
        settle();
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("t2_grant0", 32'(grant_slave_number), 0);
            check("t2_push0",  32'(push_to_fifo), 1);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            check("t2_grant1", 32'(grant_slave_number), 1);
            check("t2_push1",  32'(push_to_fifo), 1);
            cyc();
        end
        exp_cnt += 8;
        check("t2_push_end", 32'(push_to_fifo), 0);
        check("t2_count",    32'(transfer_count), exp_cnt);

        // Slave 0 starves mid-burst; the lock must keep slave 1 out.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(2'b00);
            q1.push_back(2'b00);
        end
        q0.push_back(2'b01);
        q1.push_back(2'b01);
        settle();
        cyc();
        for (int i = 0; i < 2; i++) begin
            check("t3_grant_b", 32'(grant_slave_number), 0);
            check("t3_push_b",  32'(push_to_fifo), 1);
            cyc();
        end
        gate = 2'b01;
        settle();
        for (int i = 0; i < 3; i++) begin
            check("t3_gap_push",  32'(push_to_fifo), 0);
            check("t3_gap_grant", 32'(grant_slave_number), 0);
            cyc();
        end
        gate = 2'b00;
        settle();
        for (int i = 0; i < 2; i++) begin
            check("t3_grant_tail", 32'(grant_slave_number), 0);
            check("t3_push_tail",  32'(push_to_fifo), 1);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            check("t3_grant1", 32'(grant_slave_number), 1);
            check("t3_push1",  32'(push_to_fifo), 1);
            cyc();
        end
        exp_cnt += 8;
        check("t3_push_end", 32'(push_to_fifo), 0);
        check("t3_count",    32'(transfer_count), exp_cnt);
`else
        // Without the lock, beats alternate 0,1,0,1 even though last is never set.
        q0.push_back(2'b00);
        q0.push_back(2'b00);
        q1.push_back(2'b00);
        q1.push_back(2'b00);
        settle();
        cyc();
        check("il_grant_a", 32'(grant_slave_number), 0);
        check("il_push_a",  32'(push_to_fifo), 1);
        cyc();
        check("il_grant_b", 32'(grant_slave_number), 1);
        check("il_push_b",  32'(push_to_fifo), 1);
        cyc();
        check("il_grant_c", 32'(grant_slave_number), 0);
        check("il_push_c",  32'(push_to_fifo), 1);
        cyc();
        check("il_grant_d", 32'(grant_slave_number), 1);
        check("il_push_d",  32'(push_to_fifo), 1);
        cyc();
        exp_cnt += 4;
        check("il_push_end", 32'(push_to_fifo), 0);
        check("il_count",    32'(transfer_count), exp_cnt);
`endif

        // Master FIFO full: grant and push held, no beat counted until full drops.
        q0.push_back(2'b01);
        settle();
        check("t4_req_push", 32'(push_to_fifo), 0);
        cyc();
        check("t4_grant", 32'(grant_slave_number), 0);
        master_fifo_full = 1'b1;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("t4_full_push",  32'(push_to_fifo), 1);
            check("t4_full_grant", 32'(grant_slave_number), 0);
            check("t4_full_count", 32'(transfer_count), exp_cnt);
            cyc();
        end
        master_fifo_full = 1'b0;
        settle();
        check("t4_drop_push", 32'(push_to_fifo), 1);
        cyc();
        exp_cnt += 1;
        check("t4_count",    32'(transfer_count), exp_cnt);
        check("t4_push_end", 32'(push_to_fifo), 0);

        // Slave 1 front entry belongs to master 1: never granted here.
        q1.push_back(2'b11);
        settle();
        for (int i = 0; i < 4; i++) begin
            check("t5_push",  32'(push_to_fifo), 0);
            check("t5_grant", 32'(grant_slave_number), 0);
            cyc();
        end
        check("t5_count", 32'(transfer_count), exp_cnt);
        q1.delete();
        settle();

        // Asynchronous reset while slave 1 holds the grant.
        for (int i = 0; i < 3; i++) q1.push_back(2'b00);
        q1.push_back(2'b01);
        settle();
        cyc();
        check("t6_grant", 32'(grant_slave_number), 1);
        check("t6_push",  32'(push_to_fifo), 1);
`ifdef XBAR_RETURN_BURST_LOCK_EN
        cyc();
        exp_cnt += 1;
        check("t6_mid_push",  32'(push_to_fifo), 1);
        check("t6_mid_count", 32'(transfer_count), exp_cnt);
`endif
        #2 ARESETn = 1'b0;
        #1;
        check("t6_rst_push",  32'(push_to_fifo), 0);
        check("t6_rst_grant", 32'(grant_slave_number), 0);
        check("t6_rst_count", 32'(transfer_count), 0);
        q0.delete();
        q1.delete();
        settle();
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        settle();
        q0.push_back(2'b01);
        q1.push_back(2'b01);
        settle();
        check("t6_req_push", 32'(push_to_fifo), 0);
        cyc();
        check("t6_restart_grant0", 32'(grant_slave_number), 0);
        check("t6_restart_push0",  32'(push_to_fifo), 1);
        cyc();
        check("t6_restart_grant1", 32'(grant_slave_number), 1);
        check("t6_restart_push1",  32'(push_to_fifo), 1);
        cyc();
        check("t6_end_push",  32'(push_to_fifo), 0);
        check("t6_end_count", 32'(transfer_count), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
